single_core_top: RTL and testbench



---
 rtl/single_core_top.sv | 206 ++++++++++++++++++++
 tb/tb_single_core_top.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/single_core_top.sv
// Single-core 12-bit multi-cycle processor with internal ROM/RAM.
// The built-in program multiplies two 2x2 matrices and halts.
module single_core_top (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] r1,
    output logic [11:0] r2,
    output logic [11:0] r3,
    output logic [11:0] r4,
    output logic [11:0] r5,
    output logic [11:0] r6,
    output logic [11:0] r7,
    output logic [11:0] r8,
    output logic [11:0] r9,
    output logic [11:0] r10,
    output logic [11:0] r11,
    output logic [11:0] r12,
    output logic [11:0] r13,
    output logic [11:0] r14,
    output logic [11:0] r15,
    output logic [11:0] r16,
    output logic        end_process
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd5;
    localparam logic [3:0] OP_ST  = 4'd6;
    localparam logic [3:0] OP_JNZ = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_END = 4'd15;

    // Initialisers give the reset state at power-up for rst-less use.
    state_t      state_q = S_FETCH;
    logic [5:0]  pc_q = '0;
    logic [15:0] ir_q = '0;
    logic        end_q = 1'b0;
    logic [11:0] rf_q [16] = '{default: 12'd0};
    logic [11:0] ram_rd_q = '0;
    logic [11:0] ram_q [64] = '{
        0: 12'd1, 1: 12'd2, 2: 12'd3, 3: 12'd4,
        4: 12'd5, 5: 12'd6, 6: 12'd7, 7: 12'd8,
        default: 12'd0
    };

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] alu_d;
    logic        wr_alu_d;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs1 = ir_q[7:4];
    assign rs2 = ir_q[3:0];
    assign a   = rf_q[rs1];
    assign b   = rf_q[rs2];
    assign c   = rf_q[rd];

    // R12 is the address pointer; C row-major lands in R0..R3.
    function automatic logic [15:0] rom_f(input logic [5:0] addr);
        case (addr)
            6'd0:    rom_f = 16'h1C00;
            6'd1:    rom_f = 16'h54C0;
            6'd2:    rom_f = 16'h1C01;
            6'd3:    rom_f = 16'h55C0;
            6'd4:    rom_f = 16'h1C02;
            6'd5:    rom_f = 16'h56C0;
            6'd6:    rom_f = 16'h1C03;
            6'd7:    rom_f = 16'h57C0;
            6'd8:    rom_f = 16'h1C04;
            6'd9:    rom_f = 16'h58C0;
            6'd10:   rom_f = 16'h1C05;
            6'd11:   rom_f = 16'h59C0;
            6'd12:   rom_f = 16'h1C06;
            6'd13:   rom_f = 16'h5AC0;
            6'd14:   rom_f = 16'h1C07;
            6'd15:   rom_f = 16'h5BC0;
            6'd16:   rom_f = 16'h4D48;
            6'd17:   rom_f = 16'h4E5A;
            6'd18:   rom_f = 16'h20DE;
            6'd19:   rom_f = 16'h4D49;
            6'd20:   rom_f = 16'h4E5B;
            6'd21:   rom_f = 16'h21DE;
            6'd22:   rom_f = 16'h4D68;
            6'd23:   rom_f = 16'h4E7A;
            6'd24:   rom_f = 16'h22DE;
            6'd25:   rom_f = 16'h4D69;
            6'd26:   rom_f = 16'h4E7B;
            6'd27:   rom_f = 16'h23DE;
            6'd28:   rom_f = 16'h1C08;
            6'd29:   rom_f = 16'h60C0;
            6'd30:   rom_f = 16'h1C09;
            6'd31:   rom_f = 16'h60C1;
            6'd32:   rom_f = 16'h1C0A;
            6'd33:   rom_f = 16'h60C2;
            6'd34:   rom_f = 16'h1C0B;
            6'd35:   rom_f = 16'h60C3;
            6'd36:   rom_f = 16'h5FC0;
            6'd37:   rom_f = 16'h3FF3;
            6'd38:   rom_f = 16'h7F28;
            6'd39:   rom_f = 16'h8F00;
            6'd40:   rom_f = 16'h7F2A;
            6'd41:   rom_f = 16'h1000;
            6'd42:   rom_f = 16'h9123;
            6'd43:   rom_f = 16'hF000;
            default: rom_f = 16'h0000;
        endcase
    endfunction

    always_comb begin
        alu_d    = '0;
        wr_alu_d = 1'b1;
        unique case (op)
            OP_LDI:  alu_d = {4'd0, ir_q[7:0]};
            OP_ADD:  alu_d = a + b;
            OP_SUB:  alu_d = a - b;
            OP_MUL:  alu_d = a * b;
            OP_MOV:  alu_d = a;
            default: wr_alu_d = 1'b0;
        endcase
    end

    // RAM is never cleared by reset.
    always_ff @(posedge clk) begin
        ram_rd_q <= ram_q[a[5:0]];
        if (!rst && state_q == S_EXEC && op == OP_ST) begin
            ram_q[a[5:0]] <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            end_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    ir_q    <= rom_f(pc_q);
                    pc_q    <= pc_q + 6'd1;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (wr_alu_d) begin
                        rf_q[rd] <= alu_d;
                    end
                    if (op == OP_JNZ && c != '0) begin
                        pc_q <= ir_q[5:0];
                    end
                    if (op == OP_LD) begin
                        state_q <= S_MEM;
                    end
                    if (op == OP_END) begin
                        state_q <= S_HALT;
                        end_q   <= 1'b1;
                    end
                end
                S_MEM: begin
                    rf_q[rd] <= ram_rd_q;
                    state_q  <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign r1  = rf_q[0];
    assign r2  = rf_q[1];
    assign r3  = rf_q[2];
    assign r4  = rf_q[3];
    assign r5  = rf_q[4];
    assign r6  = rf_q[5];
    assign r7  = rf_q[6];
    assign r8  = rf_q[7];
    assign r9  = rf_q[8];
    assign r10 = rf_q[9];
    assign r11 = rf_q[10];
    assign r12 = rf_q[11];
    assign r13 = rf_q[12];
    assign r14 = rf_q[13];
    assign r15 = rf_q[14];
    assign r16 = rf_q[15];
    assign end_process = end_q;

endmodule

// File: tb/tb_single_core_top.sv
// Bench for single_core_top: power-up, reset, halt and rerun checks
// against a matrix-product reference model.
module tb_single_core_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] r1, r2, r3, r4, r5, r6, r7, r8;
    logic [11:0] r9, r10, r11, r12, r13, r14, r15, r16;
    logic        end_process;
    logic [11:0] rv [16];

    int checks = 0;
    int errors = 0;
    int base_cyc;
    int cyc;
    logic [11:0] snap [16];
    int c_exp [4];

    always #5 clk = ~clk;

    single_core_top dut (
        .clk(clk), .rst(rst),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .r5(r5), .r6(r6), .r7(r7), .r8(r8),
        .r9(r9), .r10(r10), .r11(r11), .r12(r12),
        .r13(r13), .r14(r14), .r15(r15), .r16(r16),
        .end_process(end_process)
    );

    assign rv = '{r1, r2, r3, r4, r5, r6, r7, r8,
                  r9, r10, r11, r12, r13, r14, r15, r16};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_r%0d", tag, i + 1), int'(rv[i]), 0);
        end
        chk({tag, "_end"}, int'(end_process), 0);
    endtask

    // Counts edges until end_process is seen; budget 300 cycles.
    task automatic run_to_end(output int n);
        n = 0;
        while (!end_process && n < 300) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("end_in_budget", int'(end_process), 1);
    endtask

    task automatic chk_result(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_C%0d", tag, i), int'(rv[i]), c_exp[i]);
        end
    endtask

    task automatic chk_snap(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_r%0d", tag, i + 1), int'(rv[i]), int'(snap[i]));
        end
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        int ma [2][2];
        int mb [2][2];
        int k;
        ma = '{'{1, 2}, '{3, 4}};
        mb = '{'{5, 6}, '{7, 8}};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                c_exp[i*2+j] = 0;
                for (int m = 0; m < 2; m++)
                    c_exp[i*2+j] += ma[i][m] * mb[m][j];
                c_exp[i*2+j] %= 4096;
            end

        // Power-up with rst held low throughout.
        #1;
        chk_zero("powerup");
        run_to_end(base_cyc);
        chk_result("powerup");
        snap = rv;

        // Halt must be absorbing.
        repeat (10) @(negedge clk);
        chk("halt_end", int'(end_process), 1);
        chk_snap("halt");

        // Reset from HALT, held 2 cycles.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("halt_rst_edge");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("after_release");
        run_to_end(cyc);
        chk("rerun_cycles", cyc + 1, base_cyc);
        chk_result("rerun");
        chk_snap("rerun");

        // Reset mid-run: 40 cycles in, then random points.
        for (int t = 0; t < 4; t++) begin
            k = (t == 0) ? 40 : int'($urandom_range(1, 90));
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (k) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk_zero($sformatf("mid%0d_clear", k));
            rst = 1'b0;
            run_to_end(cyc);
            chk($sformatf("mid%0d_cycles", k), cyc, base_cyc);
            chk_result($sformatf("mid%0d", k));
            chk_snap($sformatf("mid%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
